count_capture: RTL and testbench



---
 rtl/count_capture.sv | 56 +++++
 tb/tb_count_capture.sv | 91 +++++++++
 2 files changed

// File: rtl/count_capture.sv
// count_capture: snapshots the counter value on each capture strobe into a show-ahead FIFO stream.
// Define COUNT_CAPTURE_DELTA_EN to store deltas from the previous accepted capture instead of raw values.
module count_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         value,
  input  logic                     capture,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MAX_LEVEL = DEPTH[AW:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic push, pop;
  logic [WIDTH-1:0] entry;
  assign out_valid = level != '0;
  assign full = level == MAX_LEVEL;
  assign pop = out_valid & out_ready;
  assign push = capture & (~full | pop);
  assign out_data = mem[rd];
`ifdef COUNT_CAPTURE_DELTA_EN
  logic [WIDTH-1:0] prev;
  assign entry = value - prev;
  always_ff @(posedge clk)
    if (!reset) prev <= '0;
    else if (push) prev <= value;
`else
  assign entry = value;
`endif
  // storage is cleared on reset so out_data reads 0 rather than X
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr] <= entry;
        wr <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (capture & full & ~pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_count_capture.sv
// tb_count_capture: randomized and directed scoreboard bench for count_capture.
module tb_count_capture;
  logic clk = 0, reset = 0, capture = 0, out_ready = 0;
  logic [7:0] value = 0;
  logic [7:0] out_data;
  logic out_valid, full, overflow;
  logic [2:0] level;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  int m_level = 0;
  bit m_ovf = 0, armed = 0;
  logic [7:0] m_ref = 0;

  count_capture #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .value(value), .capture(capture),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .level(level), .overflow(overflow));

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endfunction

  // one clock: drive inputs, let the edge happen, then advance the reference model
  task automatic cyc(input bit rn, input bit cap, input logic [7:0] v, input bit rdy);
    bit pop, push;
    reset = rn; capture = cap; value = v; out_ready = rdy;
    pop = m_level > 0 && rdy;
    push = cap && (m_level < 4 || pop);
    @(posedge clk);
    #1;
    if (!rn) begin
      exp_q.delete();
      m_level = 0; m_ovf = 0; m_ref = 0; armed = 1;
      chk("rst_data", {24'b0, out_data}, 0);
    end else begin
      if (push) begin
`ifdef COUNT_CAPTURE_DELTA_EN
        exp_q.push_back(8'(v - m_ref));
        m_ref = v;
`else
        exp_q.push_back(v);
`endif
      end
      m_level = m_level + int'(push) - int'(pop);
      if (cap && !push) m_ovf = 1;
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("level", {29'b0, level}, m_level);
    chk("full", {31'b0, full}, {31'b0, m_level == 4});
    chk("valid", {31'b0, out_valid}, {31'b0, m_level != 0});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL data: got %0h with no entry expected at %0t", out_data, $time);
      end else chk("data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
    end
  end

  initial begin
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 1, 8'h2A, 0); cyc(1, 0, 0, 1); cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'(8'h20 + i), 0);
    cyc(1, 1, 8'h55, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'(8'hF8 + i), 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 8'(8'h30 + i), 0);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 8'h77, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 8'h05, 0); cyc(1, 1, 8'h0C, 0); cyc(1, 1, 8'h03, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
